// File: rtl/fp_mul_arbiter.sv
// Round-robin front end that shares one pipelined FP32 multiplier among
// NUM_REQ clients, routes results back by tag and flushes subnormals to zero.

package fp_mul_arbiter_pkg;

  localparam int unsigned DATA_W = 32;

  // IEEE-754 single-precision zeros used when flushing subnormal results
  localparam logic [DATA_W-1:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [DATA_W-1:0] FP_NEG_ZERO = 32'h8000_0000;

  // Field view of a single-precision word
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

endpackage

module fp_mul_arbiter
  import fp_mul_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LAT     = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        resp_vld,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      fpu_vld,
  output logic [DATA_W-1:0]         fpu_a,
  output logic [DATA_W-1:0]         fpu_b,
  input  logic [DATA_W-1:0]         fpu_result,
  output logic [3:0]                inflight
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Issue tag travelling alongside an operation in the multiplier
  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] tag;
  } tag_t;

  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  gnt_idx_c;
  logic              found_c;
  logic [NUM_REQ-1:0] gnt_c;
  logic              accept_c;
  logic [DATA_W-1:0] sel_a_c;
  logic [DATA_W-1:0] sel_b_c;
  tag_t              issue_tag;
  tag_t              tag_pipe [LAT];
  tag_t              qual_c;

  // Index base+off modulo NUM_REQ; base < NUM_REQ and off <= NUM_REQ
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDX_W'(sum);
  endfunction

  // Subnormal results become a zero of the same sign
  function automatic logic [DATA_W-1:0] flush_sub(input logic [DATA_W-1:0] x);
    fp32_t f;
    f = fp32_t'(x);
    if (f.exp == 8'h00 && f.man != 23'h0)
      return f.sign ? FP_NEG_ZERO : FP_POS_ZERO;
    return x;
  endfunction

  // Search upward from ptr+1 with wrap; the last-granted client is checked last
  always_comb begin
    gnt_idx_c = '0;
    found_c   = 1'b0;
    gnt_c     = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      if (!found_c && req[wrap_idx(ptr, i)]) begin
        found_c   = 1'b1;
        gnt_idx_c = wrap_idx(ptr, i);
      end
    end
    if (found_c) gnt_c[gnt_idx_c] = 1'b1;
  end

  assign gnt      = rst_n ? gnt_c : '0;
  assign accept_c = rst_n & found_c;

  // Operand mux for the granted client
  always_comb begin
    sel_a_c = '0;
    sel_b_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx_c == IDX_W'(i)) begin
        sel_a_c = req_a[DATA_W*i +: DATA_W];
        sel_b_c = req_b[DATA_W*i +: DATA_W];
      end
    end
  end

  // Round-robin pointer remembers the last granted client
  always_ff @(posedge clk) begin
    if (!rst_n)        ptr <= IDX_W'(NUM_REQ - 1);
    else if (accept_c) ptr <= gnt_idx_c;
  end

  // Issue register: operands held when nothing is accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fpu_vld   <= 1'b0;
      fpu_a     <= '0;
      fpu_b     <= '0;
      issue_tag <= '0;
    end else begin
      fpu_vld       <= accept_c;
      issue_tag.vld <= accept_c;
      issue_tag.tag <= gnt_idx_c;
      if (accept_c) begin
        fpu_a <= sel_a_c;
        fpu_b <= sel_b_c;
      end
    end
  end

  // Tag delay line; its last stage lines up with the valid fpu_result cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < LAT; k++) tag_pipe[k] <= '0;
    end else begin
      tag_pipe[0] <= issue_tag;
      for (int unsigned k = 1; k < LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  assign qual_c = tag_pipe[LAT-1];

  // Response register: one-hot strobe to the owner, data held between results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_vld  <= '0;
      resp_data <= '0;
    end else begin
      resp_vld <= '0;
      if (qual_c.vld) begin
        resp_vld[qual_c.tag] <= 1'b1;
        resp_data            <= flush_sub(fpu_result);
      end
    end
  end

  // Outstanding-operation count: accepted but not yet delivered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({accept_c, |resp_vld})
        2'b10:   inflight <= inflight + 4'd1;
        2'b01:   inflight <= inflight - 4'd1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a fixed-latency multiplier model.

module tb_fp_mul_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned LAT     = 3;
  localparam logic [31:0] ONE     = 32'h3F80_0000;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM_REQ-1:0]     req;
  logic [32*NUM_REQ-1:0]  req_a;
  logic [32*NUM_REQ-1:0]  req_b;
  logic [NUM_REQ-1:0]     gnt;
  logic [NUM_REQ-1:0]     resp_vld;
  logic [31:0]            resp_data;
  logic                   fpu_vld;
  logic [31:0]            fpu_a;
  logic [31:0]            fpu_b;
  logic [31:0]            fpu_result;
  logic [3:0]             inflight;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  fp_mul_arbiter #(.NUM_REQ(NUM_REQ), .LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_a      (req_a),
    .req_b      (req_b),
    .gnt        (gnt),
    .resp_vld   (resp_vld),
    .resp_data  (resp_data),
    .fpu_vld    (fpu_vld),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_result (fpu_result),
    .inflight   (inflight)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: exact for x*1.0 and for 1.5*2.0, marker value otherwise
  function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
    if (b == ONE) return a;
    if (a == 32'h3FC0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return 32'hDEAD_BEEF;
  endfunction

  logic [31:0] mdl [LAT];
  always @(posedge clk) begin
    mdl[0] <= model_mul(fpu_a, fpu_b);
    for (int k = 1; k < LAT; k++) mdl[k] <= mdl[k-1];
  end
  assign fpu_result = mdl[LAT-1];

  // Response capture shared by the scenario tasks
  logic [3:0]  cap_vld  [32];
  logic [31:0] cap_data [32];
  int          cap_cyc  [32];
  int          cap_n;
  logic [3:0]  peak_inf;

  task automatic collect(input int budget);
    cap_n    = 0;
    peak_inf = 4'd0;
    for (int i = 0; i < 32; i++) begin
      cap_vld[i] = 4'h0; cap_data[i] = 32'h0; cap_cyc[i] = 0;
    end
    repeat (budget) begin
      @(negedge clk); #2;
      if (inflight > peak_inf) peak_inf = inflight;
      if (resp_vld != 4'h0 && cap_n < 32) begin
        cap_vld[cap_n]  = resp_vld;
        cap_data[cap_n] = resp_data;
        cap_cyc[cap_n]  = cyc;
        cap_n++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'hF; req_a = '0; req_b = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    checks++; if (fpu_vld !== 1'b0) begin errors++; $display("FAIL reset_fpu_vld: got %b expected 0", fpu_vld); end
    checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL reset_inflight: got %0d expected 0", inflight); end
    checks++; if (resp_vld !== 4'b0000) begin errors++; $display("FAIL reset_resp_vld: got %b expected 0000", resp_vld); end
    checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data: got %h expected 00000000", resp_data); end
    checks++; if (fpu_a !== 32'h0 || fpu_b !== 32'h0) begin errors++; $display("FAIL reset_operands: got %h/%h expected 0/0", fpu_a, fpu_b); end
    rst_n = 1'b1; req = 4'h0;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_v;
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = 32'h4100_0000 + 32'(i);
      req_b[32*i +: 32] = ONE;
    end
    fork
      begin
        @(negedge clk);
        req = 4'hF;
        for (int k = 0; k < 8; k++) begin
          #1;
          exp_v = 4'b0001 << (k % 4);
          checks++; if (gnt !== exp_v) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, gnt, exp_v); end
          @(negedge clk);
        end
        req = 4'h0;
      end
      collect(20);
    join
    checks++; if (cap_n !== 8) begin errors++; $display("FAIL rr_count: got %0d expected 8", cap_n); end
    for (int k = 0; k < 8; k++) begin
      exp_v = 4'b0001 << (k % 4);
      checks++;
      if (cap_vld[k] !== exp_v || cap_data[k] !== 32'h4100_0000 + 32'(k % 4) || cap_cyc[k] !== cap_cyc[0] + k) begin
        errors++;
        $display("FAIL rr_resp[%0d]: got vld=%b data=%h cyc=%0d expected vld=%b data=%h cyc=%0d",
                 k, cap_vld[k], cap_data[k], cap_cyc[k], exp_v, 32'h4100_0000 + 32'(k % 4), cap_cyc[0] + k);
      end
    end
  endtask

  task automatic test_single_op();
    int c0;
    c0 = 0;
    fork
      begin
        @(negedge clk);
        req_a[64 +: 32] = 32'h3FC0_0000;
        req_b[64 +: 32] = 32'h4000_0000;
        req = 4'b0100;
        c0 = cyc;
        #1;
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b expected 0100", gnt); end
        @(negedge clk);
        req = 4'h0;
        #1;
        checks++; if (fpu_vld !== 1'b1) begin errors++; $display("FAIL single_fpu_vld: got %b expected 1", fpu_vld); end
        checks++; if (fpu_a !== 32'h3FC0_0000 || fpu_b !== 32'h4000_0000) begin errors++; $display("FAIL single_operands: got %h/%h expected 3fc00000/40000000", fpu_a, fpu_b); end
        checks++; if (inflight !== 4'd1) begin errors++; $display("FAIL single_inflight_busy: got %0d expected 1", inflight); end
      end
      collect(10);
    join
    checks++; if (cap_n !== 1) begin errors++; $display("FAIL single_count: got %0d expected 1", cap_n); end
    checks++; if (cap_vld[0] !== 4'b0100 || cap_data[0] !== 32'h4040_0000) begin errors++; $display("FAIL single_resp: got %b/%h expected 0100/40400000", cap_vld[0], cap_data[0]); end
    checks++; if (cap_cyc[0] - c0 !== int'(LAT) + 2) begin errors++; $display("FAIL single_latency: got %0d expected %0d", cap_cyc[0] - c0, int'(LAT) + 2); end
    #1;
    checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL single_inflight_idle: got %0d expected 0", inflight); end
  endtask

  task automatic test_flush();
    logic [31:0] fin  [6];
    logic [31:0] fexp [6];
    fin[0] = 32'h0040_0000; fexp[0] = 32'h0000_0000;
    fin[1] = 32'h8000_0001; fexp[1] = 32'h8000_0000;
    fin[2] = 32'h7F80_0000; fexp[2] = 32'h7F80_0000;
    fin[3] = 32'h0080_0000; fexp[3] = 32'h0080_0000;
    fin[4] = 32'h7FC0_0000; fexp[4] = 32'h7FC0_0000;
    fin[5] = 32'hFF7F_FFFF; fexp[5] = 32'hFF7F_FFFF;
    fork
      begin
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
          req = 4'b0001;
          req_a[31:0] = fin[k];
          req_b[31:0] = ONE;
          #1;
          checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL flush_gnt[%0d]: got %b expected 0001", k, gnt); end
          @(negedge clk);
        end
        req = 4'h0;
      end
      collect(16);
    join
    checks++; if (cap_n !== 6) begin errors++; $display("FAIL flush_count: got %0d expected 6", cap_n); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (cap_vld[k] !== 4'b0001 || cap_data[k] !== fexp[k]) begin
        errors++;
        $display("FAIL flush_resp[%0d]: got %b/%h expected 0001/%h", k, cap_vld[k], cap_data[k], fexp[k]);
      end
    end
  endtask

  task automatic test_idle_hold();
    req = 4'h0;
    repeat (3) begin
      @(negedge clk); #1;
      checks++; if (gnt !== 4'b0000 || fpu_vld !== 1'b0 || resp_vld !== 4'b0000) begin errors++; $display("FAIL idle_strobes: got gnt=%b fpu_vld=%b resp_vld=%b expected all zero", gnt, fpu_vld, resp_vld); end
      checks++; if (fpu_a !== 32'hFF7F_FFFF || fpu_b !== ONE) begin errors++; $display("FAIL idle_operands: got %h/%h expected ff7fffff/3f800000", fpu_a, fpu_b); end
      checks++; if (resp_data !== 32'hFF7F_FFFF) begin errors++; $display("FAIL idle_resp_data: got %h expected ff7fffff", resp_data); end
    end
  endtask

  task automatic test_back_to_back();
    fork
      begin
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
          req = 4'b0010;
          req_a[63:32] = 32'h40A0_0000 + 32'(k);
          req_b[63:32] = ONE;
          #1;
          checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL b2b_gnt[%0d]: got %b expected 0010", k, gnt); end
          @(negedge clk);
        end
        req = 4'h0;
      end
      collect(14);
    join
    checks++; if (cap_n !== 5) begin errors++; $display("FAIL b2b_count: got %0d expected 5", cap_n); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (cap_vld[k] !== 4'b0010 || cap_data[k] !== 32'h40A0_0000 + 32'(k) || cap_cyc[k] !== cap_cyc[0] + k) begin
        errors++;
        $display("FAIL b2b_resp[%0d]: got %b/%h cyc=%0d expected 0010/%h cyc=%0d", k, cap_vld[k], cap_data[k], cap_cyc[k], 32'h40A0_0000 + 32'(k), cap_cyc[0] + k);
      end
    end
    checks++; if (peak_inf !== 4'd5) begin errors++; $display("FAIL b2b_peak_inflight: got %0d expected 5", peak_inf); end
  endtask

  task automatic test_reset_mid_flight();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      req = 4'b1000;
      req_a[127:96] = 32'h4200_0000 + 32'(k);
      req_b[127:96] = ONE;
      #1;
      checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL rmf_gnt[%0d]: got %b expected 1000", k, gnt); end
      @(negedge clk);
    end
    req = 4'h0;
    @(negedge clk);
    rst_n = 1'b0;
    req = 4'hF;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rmf_gnt_in_reset: got %b expected 0000", gnt); end
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'h0;
    #1;
    checks++; if (inflight !== 4'd0 || fpu_vld !== 1'b0 || resp_vld !== 4'b0000) begin errors++; $display("FAIL rmf_cleared: got inflight=%0d fpu_vld=%b resp_vld=%b expected 0/0/0000", inflight, fpu_vld, resp_vld); end
    collect(10);
    checks++; if (cap_n !== 0) begin errors++; $display("FAIL rmf_discarded: got %0d responses expected 0", cap_n); end
    @(negedge clk);
    req_a[31:0] = 32'h4040_0000;
    req_b[31:0] = ONE;
    req = 4'hF;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rmf_first_gnt: got %b expected 0001", gnt); end
    @(negedge clk);
    req = 4'h0;
    collect(10);
    checks++; if (cap_n !== 1 || cap_vld[0] !== 4'b0001 || cap_data[0] !== 32'h4040_0000) begin errors++; $display("FAIL rmf_post_resp: got n=%0d %b/%h expected n=1 0001/40400000", cap_n, cap_vld[0], cap_data[0]); end
    checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL rmf_final_inflight: got %0d expected 0", inflight); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_op();
    test_flush();
    test_idle_hold();
    test_back_to_back();
    test_reset_mid_flight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule
